// File: rtl/writeback_unit.sv
// RV32I writeback stage: accepts retiring instructions, waits for and sizes load data,
// and drives a single-cycle register-file write per instruction that produces a result.
module writeback_unit #(
  parameter int unsigned LOAD_TIMEOUT = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [31:0]      ex_instr,
  input  logic [31:0]      ex_result,
  input  logic [31:0]      ex_pc,
  input  logic             mem_rvalid,
  input  logic [31:0]      mem_rdata,
  output logic             RegWrite,
  output logic [31:0]      wb_instr,
  output logic [31:0]      Writedata,
  output logic             load_err,
  output logic [CNT_W-1:0] retired
);

  localparam int unsigned TO_W = $clog2(LOAD_TIMEOUT + 1);

  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [TO_W-1:0] to_cnt_q;
  logic [31:0]     ld_instr_q;
  logic [1:0]      ld_off_q;

  logic            accept;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            rd_nz;
  logic            is_load;
  logic            misaligned;
  logic            to_hit;
  logic [31:0]     upper_imm;
  logic            nl_write;
  logic [31:0]     nl_data;

  logic            regwrite_d;
  logic            load_err_d;
  logic [31:0]     wb_instr_d;
  logic [31:0]     writedata_d;

  assign ex_ready  = (state_q == IDLE);
  assign accept    = ex_valid & ex_ready;
  assign opcode    = ex_instr[6:0];
  assign funct3    = ex_instr[14:12];
  assign rd_nz     = |ex_instr[11:7];
  assign is_load   = (opcode == OP_LOAD);
  assign upper_imm = {ex_instr[31:12], 12'b0};
  assign to_hit    = (to_cnt_q == TO_W'(LOAD_TIMEOUT - 1));

  // Extract and extend the addressed byte/halfword from the aligned memory word
  function automatic logic [31:0] size_load(input logic [2:0]  f3,
                                            input logic [1:0]  off,
                                            input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'b0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'b0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  always_comb begin
    case (funct3)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = ex_result[0];
      default:        misaligned = |ex_result[1:0];
    endcase
  end

  // Result select for instructions that complete without memory
  always_comb begin
    nl_write = 1'b0;
    nl_data  = ex_result;
    case (opcode)
      OP_REG, OP_IMM: begin
        nl_write = 1'b1;
        nl_data  = ex_result;
      end
      OP_LUI: begin
        nl_write = 1'b1;
        nl_data  = upper_imm;
      end
      OP_AUIPC: begin
        nl_write = 1'b1;
        nl_data  = ex_pc + upper_imm;
      end
      OP_JAL, OP_JALR: begin
        nl_write = 1'b1;
        nl_data  = ex_pc + 32'd4;
      end
      default: nl_write = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept && is_load && !misaligned) state_d = WAIT_LOAD;
      WAIT_LOAD: if (mem_rvalid || to_hit)             state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Next values of the registered write-port outputs; data wins over timeout
  always_comb begin
    regwrite_d  = 1'b0;
    load_err_d  = 1'b0;
    wb_instr_d  = wb_instr;
    writedata_d = Writedata;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_load) begin
            load_err_d = misaligned;
          end else if (nl_write && rd_nz) begin
            regwrite_d  = 1'b1;
            wb_instr_d  = ex_instr;
            writedata_d = nl_data;
          end
        end
      end
      WAIT_LOAD: begin
        if (mem_rvalid) begin
          if (|ld_instr_q[11:7]) begin
            regwrite_d  = 1'b1;
            wb_instr_d  = ld_instr_q;
            writedata_d = size_load(ld_instr_q[14:12], ld_off_q, mem_rdata);
          end
        end else if (to_hit) begin
          load_err_d = 1'b1;
        end
      end
      default: regwrite_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite  <= 1'b0;
      wb_instr  <= 32'b0;
      Writedata <= 32'b0;
      load_err  <= 1'b0;
    end else begin
      RegWrite  <= regwrite_d;
      wb_instr  <= wb_instr_d;
      Writedata <= writedata_d;
      load_err  <= load_err_d;
    end
  end

  // Load context, wait counter (zero whenever idle) and retire count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_instr_q <= 32'b0;
      ld_off_q   <= 2'b0;
      to_cnt_q   <= '0;
      retired    <= '0;
    end else begin
      if (accept) begin
        ld_instr_q <= ex_instr;
        ld_off_q   <= ex_result[1:0];
        retired    <= retired + CNT_W'(1);
      end
      if (state_q == WAIT_LOAD) to_cnt_q <= to_cnt_q + TO_W'(1);
      else                      to_cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed scenarios plus a randomized instruction stream
// checked against an architectural model of RV32I writeback.
module tb_writeback_unit;

  localparam int unsigned LOAD_TIMEOUT = 16;
  localparam int unsigned CNT_W        = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ex_valid;
  logic             ex_ready;
  logic [31:0]      ex_instr;
  logic [31:0]      ex_result;
  logic [31:0]      ex_pc;
  logic             mem_rvalid;
  logic [31:0]      mem_rdata;
  logic             RegWrite;
  logic [31:0]      wb_instr;
  logic [31:0]      Writedata;
  logic             load_err;
  logic [CNT_W-1:0] retired;

  int checks = 0;
  int errors = 0;
  logic [31:0]      exp_wb_instr = 32'b0;
  logic [31:0]      exp_wdata    = 32'b0;
  logic [CNT_W-1:0] exp_retired  = '0;

  writeback_unit #(.LOAD_TIMEOUT(LOAD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_instr(ex_instr), .ex_result(ex_result), .ex_pc(ex_pc),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .RegWrite(RegWrite),
    .wb_instr(wb_instr), .Writedata(Writedata), .load_err(load_err), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_one(input logic [31:0] instr, input logic [31:0] res, input logic [31:0] pc);
    ex_valid  = 1'b1;
    ex_instr  = instr;
    ex_result = res;
    ex_pc     = pc;
    tick();
    ex_valid  = 1'b0;
    exp_retired = exp_retired + 1;
  endtask

  // Architectural model
  function automatic int unsigned load_bytes(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] word);
    logic [31:0] v;
    v = word >> (8 * int'(off));
    if (load_bytes(f3) == 1) begin
      v = v % 256;
      if (f3 == 3'd0 && v >= 128) v = v - 32'd256;
    end else if (load_bytes(f3) == 2) begin
      v = v % 65536;
      if (f3 == 3'd1 && v >= 32768) v = v - 32'd65536;
    end
    return v;
  endfunction

  function automatic bit produces_value(input logic [31:0] instr);
    logic [6:0] op;
    op = instr[6:0];
    return op == 7'h33 || op == 7'h13 || op == 7'h37 || op == 7'h17 || op == 7'h6F || op == 7'h67;
  endfunction

  function automatic logic [31:0] value_of(input logic [31:0] instr, input logic [31:0] res, input logic [31:0] pc);
    logic [6:0]  op;
    logic [31:0] imm;
    op  = instr[6:0];
    imm = instr & 32'hFFFF_F000;
    if (op == 7'h37) return imm;
    if (op == 7'h17) return pc + imm;
    if (op == 7'h6F || op == 7'h67) return pc + 32'd4;
    return res;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; ex_valid = 1'b0; ex_instr = '0; ex_result = '0; ex_pc = '0;
    mem_rvalid = 1'b0; mem_rdata = '0;
    #3;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    exp_wb_instr = '0; exp_wdata = '0; exp_retired = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %b want 0", RegWrite); end
    checks++; if (wb_instr !== 32'h0 || Writedata !== 32'h0) begin errors++; $display("FAIL reset_data got %h/%h want 0/0", wb_instr, Writedata); end
    checks++; if (load_err !== 1'b0 || retired !== '0) begin errors++; $display("FAIL reset_err_ret got %b/%0d want 0/0", load_err, retired); end
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ex_ready); end
  endtask

  task automatic test_addi();
    accept_one(32'h00A0_0293, 32'd10, 32'h100);
    checks++; if (RegWrite !== 1'b1 || Writedata !== 32'hA || wb_instr[11:7] !== 5'd5)
      begin errors++; $display("FAIL addi_write got rw=%b wd=%h rd=%0d want 1/0000000a/5", RegWrite, Writedata, wb_instr[11:7]); end
    tick();
    checks++; if (RegWrite !== 1'b0 || Writedata !== 32'hA) begin errors++; $display("FAIL addi_pulse got rw=%b wd=%h want 0/0000000a", RegWrite, Writedata); end
    checks++; if (retired !== 32'd1) begin errors++; $display("FAIL addi_retired got %0d want 1", retired); end
    exp_wb_instr = 32'h00A0_0293; exp_wdata = 32'hA;
  endtask

  task automatic test_lb_lbu();
    logic [31:0] instrs [2];
    logic [31:0] wants [2];
    instrs[0] = 32'h0000_0303; wants[0] = 32'hFFFF_FF80;
    instrs[1] = 32'h0000_4303; wants[1] = 32'h0000_0080;
    for (int i = 0; i < 2; i++) begin
      accept_one(instrs[i], 32'h0000_1003, 32'h200);
      checks++; if (ex_ready !== 1'b0 || RegWrite !== 1'b0) begin errors++; $display("FAIL lb_wait0 got ready=%b rw=%b want 0/0", ex_ready, RegWrite); end
      tick();
      checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL lb_wait1 got ready=%b want 0", ex_ready); end
      mem_rvalid = 1'b1; mem_rdata = 32'h80FF_FFFF;
      tick();
      mem_rvalid = 1'b0;
      checks++; if (RegWrite !== 1'b1 || Writedata !== wants[i] || wb_instr !== instrs[i])
        begin errors++; $display("FAIL lb_data%0d got rw=%b wd=%h ins=%h want 1/%h/%h", i, RegWrite, Writedata, wb_instr, wants[i], instrs[i]); end
      checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL lb_ready_after got %b want 1", ex_ready); end
      exp_wb_instr = instrs[i]; exp_wdata = wants[i];
    end
  endtask

  task automatic test_misaligned();
    accept_one(32'h0000_2383, 32'h0000_0102, 32'h300);
    checks++; if (load_err !== 1'b1 || RegWrite !== 1'b0 || ex_ready !== 1'b1)
      begin errors++; $display("FAIL misalign got err=%b rw=%b ready=%b want 1/0/1", load_err, RegWrite, ex_ready); end
    tick();
    checks++; if (load_err !== 1'b0 || retired !== exp_retired) begin errors++; $display("FAIL misalign_after got err=%b ret=%0d want 0/%0d", load_err, retired, exp_retired); end
  endtask

  task automatic test_timeout();
    int waited;
    bit seen;
    accept_one(32'h0000_2383, 32'h0000_0100, 32'h400);
    waited = 0; seen = 0;
    while (!seen && waited < 3 * LOAD_TIMEOUT) begin
      tick();
      waited++;
      if (load_err === 1'b1) seen = 1;
    end
    checks++; if (!seen || waited != LOAD_TIMEOUT)
      begin errors++; $display("FAIL timeout_cycles got seen=%0d cycles=%0d want 1/%0d", seen, waited, LOAD_TIMEOUT); end
    checks++; if (RegWrite !== 1'b0 || ex_ready !== 1'b1) begin errors++; $display("FAIL timeout_state got rw=%b ready=%b want 0/1", RegWrite, ex_ready); end
    tick();
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL timeout_pulse got %b want 0", load_err); end
  endtask

  task automatic test_rvalid_at_limit();
    accept_one(32'h0000_2383, 32'h0000_0104, 32'h500);
    repeat (LOAD_TIMEOUT - 1) tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    checks++; if (RegWrite !== 1'b1 || Writedata !== 32'h1234_5678 || load_err !== 1'b0)
      begin errors++; $display("FAIL limit_data_wins got rw=%b wd=%h err=%b want 1/12345678/0", RegWrite, Writedata, load_err); end
    exp_wb_instr = 32'h0000_2383; exp_wdata = 32'h1234_5678;
  endtask

  task automatic test_jal_wrap();
    accept_one(32'h0000_006F, 32'h0, 32'hFFFF_FFFC);
    checks++; if (RegWrite !== 1'b0 || Writedata !== exp_wdata) begin errors++; $display("FAIL jal_x0 got rw=%b wd=%h want 0/%h", RegWrite, Writedata, exp_wdata); end
    accept_one(32'h0000_00EF, 32'h0, 32'hFFFF_FFFC);
    checks++; if (RegWrite !== 1'b1 || Writedata !== 32'h0) begin errors++; $display("FAIL jal_x1 got rw=%b wd=%h want 1/00000000", RegWrite, Writedata); end
    exp_wb_instr = 32'h0000_00EF; exp_wdata = 32'h0;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_rvalid = 1'b0;
    checks++; if (RegWrite !== 1'b0 || Writedata !== 32'h0 || ex_ready !== 1'b1)
      begin errors++; $display("FAIL idle_rvalid got rw=%b wd=%h ready=%b want 0/0/1", RegWrite, Writedata, ex_ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] instr, res, pc;
    ex_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      instr = {$urandom_range(0, 32'hFFFFF), 3'b000, 5'($urandom_range(1, 31)), (i % 2 == 0) ? 7'h13 : 7'h37};
      res = $urandom; pc = $urandom;
      ex_instr = instr; ex_result = res; ex_pc = pc;
      tick();
      exp_retired = exp_retired + 1;
      exp_wdata = value_of(instr, res, pc); exp_wb_instr = instr;
      checks++; if (RegWrite !== 1'b1 || Writedata !== exp_wdata || wb_instr !== instr)
        begin errors++; $display("FAIL b2b_%0d got rw=%b wd=%h ins=%h want 1/%h/%h", i, RegWrite, Writedata, wb_instr, exp_wdata, instr); end
    end
    ex_valid = 1'b0;
    tick();
    checks++; if (RegWrite !== 1'b0 || retired !== exp_retired) begin errors++; $display("FAIL b2b_end got rw=%b ret=%0d want 0/%0d", RegWrite, retired, exp_retired); end
  endtask

  task automatic test_random();
    logic [6:0]  ops [10];
    logic [31:0] instr, res, pc, word;
    logic [2:0]  f3;
    logic [4:0]  rd;
    bit          exp_rw, exp_err, done;
    int          d, k;
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h03, 7'h23, 7'h63};
    for (int t = 0; t < 150; t++) begin
      f3 = 3'($urandom);
      rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      instr = {20'($urandom) , 12'b0} | {17'b0, f3, rd, ops[$urandom_range(0, 9)]};
      instr[14:12] = f3;
      res = $urandom; pc = $urandom;
      if ($urandom_range(0, 2) != 0) res[1:0] = 2'b00;
      ex_valid = 1'b1; ex_instr = instr; ex_result = res; ex_pc = pc;
      checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL rnd_ready%0d got %b want 1", t, ex_ready); end
      tick();
      ex_valid = 1'b0;
      exp_retired = exp_retired + 1;
      exp_rw = 0; exp_err = 0;
      if (instr[6:0] == 7'h03) begin
        if (int'(res[1:0]) % load_bytes(f3) != 0) exp_err = 1;
        else begin
          d = $urandom_range(0, LOAD_TIMEOUT + 3);
          if (t % 17 == 0) d = LOAD_TIMEOUT - 1;
          word = $urandom; k = 0; done = 0;
          while (!done) begin
            checks++; if (ex_ready !== 1'b0 || RegWrite !== 1'b0 || load_err !== 1'b0)
              begin errors++; $display("FAIL rnd_wait%0d got ready=%b rw=%b err=%b want 0/0/0", t, ex_ready, RegWrite, load_err); end
            ex_valid = 1'($urandom);
            mem_rvalid = (k == d);
            mem_rdata = (k == d) ? word : $urandom;
            tick();
            mem_rvalid = 1'b0; ex_valid = 1'b0;
            if (k == d) begin
              done = 1;
              if (rd != 0) begin exp_rw = 1; exp_wdata = load_value(f3, res[1:0], word); exp_wb_instr = instr; end
            end else if (k == LOAD_TIMEOUT - 1) begin
              done = 1; exp_err = 1;
            end
            k++;
          end
        end
      end else if (produces_value(instr) && rd != 0) begin
        exp_rw = 1; exp_wdata = value_of(instr, res, pc); exp_wb_instr = instr;
      end
      checks++; if (RegWrite !== exp_rw || load_err !== exp_err || Writedata !== exp_wdata || wb_instr !== exp_wb_instr)
        begin errors++; $display("FAIL rnd_out%0d ins=%h got rw=%b err=%b wd=%h wi=%h want %b/%b/%h/%h", t, instr, RegWrite, load_err, Writedata, wb_instr, exp_rw, exp_err, exp_wdata, exp_wb_instr); end
      checks++; if (retired !== exp_retired) begin errors++; $display("FAIL rnd_retired%0d got %0d want %0d", t, retired, exp_retired); end
      if ($urandom_range(0, 3) == 0) begin
        mem_rvalid = 1'($urandom); mem_rdata = $urandom;
        tick();
        mem_rvalid = 1'b0;
        checks++; if (RegWrite !== 1'b0 || load_err !== 1'b0 || Writedata !== exp_wdata)
          begin errors++; $display("FAIL rnd_idle%0d got rw=%b err=%b wd=%h want 0/0/%h", t, RegWrite, load_err, Writedata, exp_wdata); end
      end
    end
  endtask

  task automatic test_reset_midload();
    accept_one(32'h0000_2383, 32'h0000_0100, 32'h600);
    tick();
    rst_n = 1'b0;
    #1;
    checks++; if (ex_ready !== 1'b1 || retired !== '0 || RegWrite !== 1'b0)
      begin errors++; $display("FAIL rst_mid got ready=%b ret=%0d rw=%b want 1/0/0", ex_ready, retired, RegWrite); end
    rst_n = 1'b1;
    exp_wb_instr = '0; exp_wdata = '0; exp_retired = '0;
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_rvalid = 1'b0;
    checks++; if (RegWrite !== 1'b0 || load_err !== 1'b0 || Writedata !== 32'h0 || retired !== '0)
      begin errors++; $display("FAIL rst_late_rvalid got rw=%b err=%b wd=%h ret=%0d want 0/0/0/0", RegWrite, load_err, Writedata, retired); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lb_lbu();
    test_misaligned();
    test_timeout();
    test_rvalid_at_limit();
    test_jal_wrap();
    test_back_to_back();
    test_random();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
